// File: rtl/keypad_matrix_emulator.sv
// Emulates one key of a 4x4 active-low scanned keypad, including contact
// bounce on press and release, so a scanning controller can be exercised.
module keypad_matrix_emulator #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int TOGGLE_PERIOD = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  column,
    input  logic        press_valid,
    input  logic [3:0]  press_key,
    input  logic [15:0] hold_cycles,
    output logic        press_ready,
    output logic        contact,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HELD,
        BOUNCE_OUT,
        GAP
    } state_t;

    localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TOGGLE_LEN  = 16'(TOGGLE_PERIOD);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic [15:0] hold_q, hold_d;
    logic        contact_q, contact_d;
    logic [15:0] toggle_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            key_q     <= 4'd0;
            hold_q    <= 16'd1;
            contact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            contact_q <= contact_d;
        end
    end

    // cnt_q holds the number of cycles already spent in the current phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        key_d   = key_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (press_valid) begin
                    state_d = BOUNCE_IN;
                    key_d   = press_key;
                    hold_d  = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
                end
            end
            BOUNCE_IN: begin
                if (cnt_q == BOUNCE_LAST) begin
                    state_d = HELD;
                    cnt_d   = 16'd0;
                end
            end
            HELD: begin
                if (cnt_q == hold_q - 16'd1) begin
                    state_d = BOUNCE_OUT;
                    cnt_d   = 16'd0;
                end
            end
            BOUNCE_OUT: begin
                if (cnt_q == BOUNCE_LAST) begin
                    state_d = GAP;
                    cnt_d   = 16'd0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Contact is registered, so it is derived from the phase being entered.
    always_comb begin
        contact_d  = 1'b0;
        toggle_idx = cnt_d / TOGGLE_LEN;
        case (state_d)
            BOUNCE_IN:  contact_d = ~toggle_idx[0];
            HELD:       contact_d = 1'b1;
            BOUNCE_OUT: contact_d = toggle_idx[0];
            default:    contact_d = 1'b0;
        endcase
    end

    always_comb begin
        column = 4'b1111;
        if (contact_q && !row[key_q[3:2]]) begin
            column[key_q[1:0]] = 1'b0;
        end
    end

    assign contact     = contact_q;
    assign press_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == GAP) && (cnt_q == GAP_LAST);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Randomized bench for keypad_matrix_emulator: a per-cycle queue of expected
// contact/done values is built at each acceptance and compared every cycle.
module tb_keypad_matrix_emulator;

    localparam int BOUNCE = 64;
    localparam int TOGGLE = 8;
    localparam int GAP    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  column;
    logic        press_valid;
    logic [3:0]  press_key;
    logic [15:0] hold_cycles;
    logic        press_ready;
    logic        contact;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;

    // Each entry is {done, contact} for one future cycle of the active press.
    logic [1:0] exp_q[$];
    logic [3:0] model_key;

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(BOUNCE),
        .TOGGLE_PERIOD(TOGGLE),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .column(column),
        .press_valid(press_valid),
        .press_key(press_key),
        .hold_cycles(hold_cycles),
        .press_ready(press_ready),
        .contact(contact),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic void buildPress(input logic [3:0] key, input logic [15:0] hold);
        int h;
        h = (hold == 16'd0) ? 1 : int'(hold);
        model_key = key;
        for (int i = 0; i < BOUNCE; i++) exp_q.push_back({1'b0, ((i / TOGGLE) % 2) == 0});
        for (int i = 0; i < h; i++)      exp_q.push_back(2'b01);
        for (int i = 0; i < BOUNCE; i++) exp_q.push_back({1'b0, ((i / TOGGLE) % 2) == 1});
        for (int i = 0; i < GAP; i++)    exp_q.push_back({(i == GAP - 1), 1'b0});
    endfunction

    function automatic logic [3:0] expectedColumn(input logic c);
        logic [3:0] col;
        col = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            if (c && k == int'(model_key[1:0]) && row[model_key[3:2]] == 1'b0) col[k] = 1'b0;
        end
        return col;
    endfunction

    task automatic checkAll();
        logic exp_contact;
        logic exp_done;
        logic active;
        active      = (exp_q.size() > 0);
        exp_contact = active ? exp_q[0][0] : 1'b0;
        exp_done    = active ? exp_q[0][1] : 1'b0;
        checkOutput("contact", 16'(contact), 16'(exp_contact));
        checkOutput("done", 16'(done), 16'(exp_done));
        checkOutput("busy", 16'(busy), 16'(active));
        checkOutput("press_ready", 16'(press_ready), 16'(!active));
        checkOutput("column", 16'(column), 16'(expectedColumn(exp_contact)));
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] k,
                                 input logic [15:0] h, input logic [3:0] r);
        press_valid = v;
        press_key   = k;
        hold_cycles = h;
        row         = r;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            model_key = 4'd0;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (press_valid) begin
            buildPress(press_key, hold_cycles);
            accepts++;
        end
        @(negedge clk);
        checkAll();
    endtask

    // Accept one press, then run it to completion with noisy request inputs.
    task automatic runPress(input logic [3:0] k, input logic [15:0] h,
                            input logic [3:0] r, input bit fixed_row);
        int budget;
        applyStimulus(1'b1, k, h, r);
        tick();
        budget = 0;
        while (exp_q.size() > 0 && budget < 2000) begin
            applyStimulus(1'($urandom_range(0, 1)) & 1'b0, 4'($urandom), 16'($urandom),
                          fixed_row ? r : 4'($urandom));
            tick();
            budget++;
        end
        if (budget >= 2000) checkOutput("press_timeout", 16'd1, 16'd0);
        applyStimulus(1'b0, 4'($urandom), 16'd0, 4'($urandom));
        tick();
    endtask

    initial begin
        int start_accepts;
        int budget;
        model_key = 4'd0;
        reset = 1'b1;
        applyStimulus(1'b1, 4'hF, 16'd5, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAll();
        reset = 1'b0;

        // Idle scan with no request: column must stay released.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'($urandom), 16'($urandom), ~(4'b0001 << (i % 4)));
            tick();
        end

        runPress(4'h6, 16'd100, 4'b1011, 1'b1);
        runPress(4'h6, 16'd100, 4'b1110, 1'b1);
        runPress(4'h9, 16'd0, 4'($urandom), 1'b0);

        // Continuous request with changing key: exactly one acceptance per IDLE visit.
        start_accepts = accepts;
        budget = 0;
        while ((accepts - start_accepts < 2 || exp_q.size() > 0) && budget < 3000) begin
            applyStimulus(1'b1, 4'($urandom), 16'($urandom_range(0, 20)), 4'($urandom));
            tick();
            budget++;
        end
        checkOutput("continuous_accepts", 16'(accepts - start_accepts), 16'd2);
        applyStimulus(1'b0, 4'd0, 16'd0, 4'($urandom));
        tick();

        // Reset in the middle of HELD, held across an edge with a pending request.
        applyStimulus(1'b1, 4'hD, 16'd100, 4'b0111);
        tick();
        for (int i = 0; i < BOUNCE + 40; i++) begin
            applyStimulus(1'b0, 4'($urandom), 16'($urandom), 4'b0111);
            tick();
        end
        checkOutput("held_before_reset", 16'(contact), 16'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        model_key = 4'd0;
        checkAll();
        applyStimulus(1'b1, 4'h3, 16'd4, 4'($urandom));
        tick();
        reset = 1'b0;
        runPress(4'h3, 16'd4, 4'b1110, 1'b1);

        for (int n = 0; n < 3; n++) begin
            runPress(4'($urandom), 16'($urandom_range(0, 30)), 4'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
